// File: rtl/click_capture.sv
// Debounced click capture: synchronizes a bouncy button, accepts a press after
// DEBOUNCE_CYCLES stable samples, latches the clamped cursor and counts clicks.
module click_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int X_MAX           = 640,
  parameter int Y_MAX           = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [9:0] cursor_x,
  input  logic [8:0] cursor_y,
  input  logic       pr_reset,
  output logic       pressed,
  output logic [9:0] x_game,
  output logic [8:0] y_game,
  output logic [7:0] click_count
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]  X_LIM    = 10'(X_MAX - 1);
  localparam logic [8:0]  Y_LIM    = 9'(Y_MAX - 1);

  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, btn_s_q;
  logic        pressed_q, pressed_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [7:0]  count_q, count_d;
  logic [9:0]  x_clamp;
  logic [8:0]  y_clamp;

  assign x_clamp = (cursor_x > X_LIM) ? X_LIM : cursor_x;
  assign y_clamp = (cursor_y > Y_LIM) ? Y_LIM : cursor_y;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = ARMING;
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Capture edge: pr_reset is not looked at here, so the capture wins.
          state_d   = HELD;
          cnt_d     = '0;
          pressed_d = 1'b1;
          x_d       = x_clamp;
          y_d       = y_clamp;
          count_d   = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HELD: begin
        if (pr_reset) begin
          state_d   = RELEASE;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end
      end
      RELEASE: begin
        // Any high sample restarts the release debounce.
        if (btn_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync1_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      pressed_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= btn_raw;
      btn_s_q   <= sync1_q;
      pressed_q <= pressed_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
    end
  end

  assign pressed     = pressed_q;
  assign x_game      = x_q;
  assign y_game      = y_q;
  assign click_count = count_q;

endmodule

// File: doc/click_capture.md
CLICK_CAPTURE -- requirements
Module: click_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a press or a release (legal range 2..65535).
REQ-002 Parameter X_MAX, default 640: exclusive upper bound of captured x coordinate.
REQ-003 Parameter Y_MAX, default 480: exclusive upper bound of captured y coordinate.
REQ-004 clock  input  1  single master clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  1  asynchronous, bouncy mouse/push-button level.
REQ-007 cursor_x  input  10  live cursor x, synchronous to clock.
REQ-008 cursor_y  input  9  live cursor y, synchronous to clock.
REQ-009 pr_reset  input  1  processor clear strobe, level-sampled each edge.
REQ-010 pressed  output  1  registered; 1 = accepted click awaiting processor service.
REQ-011 x_game  output  10  registered x coordinate captured at click acceptance.
REQ-012 y_game  output  9  registered y coordinate captured at click acceptance.
REQ-013 click_count  output  8  registered count of accepted clicks.

Function
REQ-014 btn_raw SHALL pass through a 2-flop synchronizer; btn_s (second flop) is the only button value used by the FSM.
REQ-015 FSM states SHALL be IDLE, ARMING, HELD, RELEASE, with a 16-bit stability counter cnt.
REQ-016 IDLE: btn_s=1 SHALL move to ARMING with cnt=0; otherwise remain.
REQ-017 ARMING: btn_s=0 SHALL return to IDLE; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 SHALL move to HELD and capture; otherwise cnt SHALL increment.
REQ-018 Capture SHALL set pressed=1, x_game=min(cursor_x, X_MAX-1), y_game=min(cursor_y, Y_MAX-1) from the same edge, and increment click_count modulo 256 (255 wraps to 0).
REQ-019 With btn_raw first sampled high at edge 1 and held, pressed SHALL be visible after edge DEBOUNCE_CYCLES+3.
REQ-020 HELD: pressed, x_game, y_game SHALL hold; pr_reset=1 SHALL clear pressed on that edge and move to RELEASE with cnt=0.
REQ-021 RELEASE: btn_s=1 SHALL reset cnt to 0; btn_s=0 and cnt=DEBOUNCE_CYCLES-1 SHALL move to IDLE; otherwise cnt SHALL increment.
REQ-022 pr_reset in IDLE, ARMING, or RELEASE SHALL have no effect.
REQ-023 pr_reset asserted on the capture edge (ARMING->HELD) SHALL be ignored; the capture wins and pressed rises.
REQ-024 x_game and y_game SHALL change only on a capture edge; cursor motion at any other time SHALL not affect them.
REQ-025 A press shorter than DEBOUNCE_CYCLES stable samples SHALL produce no capture and no count change.
REQ-026 Holding the button through and after service SHALL not re-trigger; a new click requires a debounced release via RELEASE then IDLE.
REQ-027 cnt SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE, cnt=0, both synchronizer flops=0, pressed=0, x_game=0, y_game=0, click_count=0, overriding all other inputs in any state.
REQ-029 Deasserting reset mid-press SHALL require a full new debounce before any capture.

Verification
REQ-030 DEBOUNCE_CYCLES=4, cursor=(100,200), btn_raw high from edge 1 -> pressed=1, x_game=100, y_game=200, click_count=1 after edge 7, not earlier.
REQ-031 btn_raw high for edges 1-4 then low (glitch shorter than debounce) -> pressed stays 0, click_count stays 0.
REQ-032 After capture, pulse pr_reset one cycle while button held; keep button held 20 cycles -> pressed=0 after the pr_reset edge, no re-capture; after release plus 4 stable low samples and a new press -> click_count=2.
REQ-033 cursor=(700,500) at capture with defaults -> x_game=639, y_game=479; cursor motion during HELD leaves outputs unchanged.
REQ-034 Preload click_count=255 via 255 complete clicks, perform one more -> click_count=0, pressed=1.
REQ-035 reset asserted while in HELD with pressed=1 -> all outputs 0 after that edge; pr_reset on the capture edge of a later click -> pressed=1 regardless.
